// File: rtl/counter_sequencer_if.sv
// Control/feedback bus between the sequencer and the loadable up/down counter.
// The sequencer is the master: it drives direction, enable and load, and it
// observes the counter value coming back from the datapath.
interface counter_sequencer_if #(
  parameter int N = 32
);
  logic         cnt_dec;
  logic         cnt_enable;
  logic         cnt_load;
  logic [N-1:0] cnt_load_value;
  logic [N-1:0] counterN;

  // Sequencer side: issues counter controls, reads counter value.
  modport master (
    output cnt_dec,
    output cnt_enable,
    output cnt_load,
    output cnt_load_value,
    input  counterN
  );

  // Counter side: obeys controls, returns its current value.
  modport slave (
    input  cnt_dec,
    input  cnt_enable,
    input  cnt_load,
    input  cnt_load_value,
    output counterN
  );
endinterface

// File: rtl/counter_sequencer.sv
// Down-count timer controller. On an accepted start it latches the period,
// loads it into the external counter, lets the counter run down to zero and
// then pulses done. Supports one-shot / auto-reload, pause, abort via stop,
// and a saturating count of expiries since the last accepted start.
//
// Moore FSM with registered state; cnt_enable is the only output that also
// looks at live inputs so the counter freezes in the very cycle pause or stop
// rises, and never steps past zero.
module counter_sequencer #(
  parameter int N = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                pause,
  input  logic                auto_reload,
  input  logic [N-1:0]        period,
  counter_sequencer_if.master cnt,
  output logic                busy,
  output logic                done,
  output logic [7:0]          expire_count,
  output logic [2:0]          state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RUN    = 3'd2,
    S_PAUSED = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [7:0] EXPIRE_MAX = 8'hFF;

  state_t       state_q;
  state_t       state_d;
  logic [N-1:0] period_q;
  logic [7:0]   expire_q;

  logic         count_zero;
  logic         start_accept;
  logic         expire_event;

  logic         load_o;
  logic         enable_o;
  logic         done_o;
  logic         busy_o;

  // Counter has reached zero: completion condition while running.
  assign count_zero = (cnt.counterN == '0);

  // A start only counts in IDLE, and an abort in the same cycle wins.
  assign start_accept = (state_q == S_IDLE) && start && !stop;

  // An expiry is the RUN -> DONE hop; stop beats completion.
  assign expire_event = (state_q == S_RUN) && count_zero && !stop;

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // values present before the edge, independent of statement order.
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: stop overrides everything, then per-state rules.
  always_comb begin
    // NOTE: default assignment first, so every path assigns state_d and no
    // latch is inferred.
    state_d = state_q;
    if (stop) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          // Pause is deliberately ignored here; the load always completes.
          state_d = S_RUN;
        end
        S_RUN: begin
          if (count_zero) begin
            state_d = S_DONE;
          end else if (pause) begin
            state_d = S_PAUSED;
          end
        end
        S_PAUSED: begin
          if (!pause) begin
            state_d = S_RUN;
          end
        end
        S_DONE: begin
          state_d = auto_reload ? S_LOAD : S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Output logic: Moore decode of the current state plus the gated enable.
  always_comb begin
    load_o   = 1'b0;
    enable_o = 1'b0;
    done_o   = 1'b0;
    busy_o   = (state_q != S_IDLE);
    unique case (state_q)
      S_LOAD: begin
        load_o = 1'b1;
      end
      S_RUN: begin
        // Freeze in the same cycle pause, stop or reset is seen, and never
        // decrement from zero.
        enable_o = !count_zero && !pause && !stop && !reset;
      end
      S_DONE: begin
        done_o = 1'b1;
      end
      default: begin
        load_o = 1'b0;
      end
    endcase
  end

  // Period capture and saturating expiry count.
  always_ff @(posedge clock) begin
    if (reset) begin
      period_q <= '0;
      expire_q <= '0;
    end else if (start_accept) begin
      period_q <= period;
      expire_q <= '0;
    end else if (expire_event && (expire_q != EXPIRE_MAX)) begin
      expire_q <= expire_q + 8'd1;
    end
  end

  assign cnt.cnt_dec        = 1'b1;
  assign cnt.cnt_enable     = enable_o;
  assign cnt.cnt_load       = load_o;
  assign cnt.cnt_load_value = period_q;

  assign busy         = busy_o;
  assign done         = done_o;
  assign expire_count = expire_q;
  assign state_o      = state_q;

  // Load and enable belong to different states and must never overlap.
  a_load_enable_exclusive : assert property (
    @(posedge clock) disable iff (reset) !(cnt.cnt_load && cnt.cnt_enable)
  );

  // The counter is never asked to step below zero.
  a_no_wrap : assert property (
    @(posedge clock) disable iff (reset) cnt.cnt_enable |-> !count_zero
  );

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: a behavioural counter closes the feedback loop,
// a vector table covers the basic one-shot, hand sequences cover pause, stop,
// auto-reload, period 0, saturation and reset, and a randomized phase compares
// against a schedule-based reference model.
module tb_counter_sequencer;

  localparam int N = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic         stop;
  logic         pause;
  logic         auto_reload;
  logic [N-1:0] period;
  logic         busy;
  logic         done;
  logic [7:0]   expire_count;
  logic [2:0]   state_o;
  logic [N-1:0] counter_q = '0;

  int checks = 0;
  int errors = 0;

  counter_sequencer_if #(.N(N)) bus ();

  counter_sequencer #(.N(N)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .pause        (pause),
    .auto_reload  (auto_reload),
    .period       (period),
    .cnt          (bus),
    .busy         (busy),
    .done         (done),
    .expire_count (expire_count),
    .state_o      (state_o)
  );

  always #5 clock = ~clock;

  // Behavioural model of the lab counter: load beats enable, dec counts down.
  always @(posedge clock) begin
    if (bus.cnt_load) begin
      counter_q <= bus.cnt_load_value;
    end else if (bus.cnt_enable) begin
      counter_q <= bus.cnt_dec ? counter_q - 1'b1 : counter_q + 1'b1;
    end
  end
  assign bus.counterN = counter_q;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge; outputs are then sampled
  // 1 time unit later, well away from the rising edge.
  task automatic cycle_in(input bit rs, input bit st, input bit sp,
                          input bit pa, input bit ar, input logic [N-1:0] per);
    @(negedge clock);
    reset       = rs;
    start       = st;
    stop        = sp;
    pause       = pa;
    auto_reload = ar;
    period      = per;
    #1;
  endtask

  typedef struct {
    bit st, sp, pa, ar;
    int per;
    int e_state, e_busy, e_done, e_load, e_en, e_cnt, e_exp, e_lv;
  } vec_t;

  vec_t vecs[11];
  int   dq[$];
  int   first_done;
  int   n_done;
  bit   seen_idle;

  // Randomized-phase stimulus and reference model state.
  bit r_start, r_stop, r_pause, r_ar;
  int r_per;
  bit m_active, m_held, window, e_en;
  int m_load_at, m_done_at, m_per, m_cnt, m_exp;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion by %0t, expected summary", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
    auto_reload = 1'b0; period = '0;

    // ---------------- reset state ----------------
    cycle_in(1, 0, 0, 0, 0, 0);
    cycle_in(1, 0, 0, 0, 0, 0);
    check("rst_state", state_o, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_load", bus.cnt_load, 0);
    check("rst_enable", bus.cnt_enable, 0);
    check("rst_dec", bus.cnt_dec, 1);
    check("rst_load_value", bus.cnt_load_value, 0);
    check("rst_expire", expire_count, 0);

    // ---------------- one-shot, period 5, start at cycle 0 ----------------
    //            st sp pa ar per  state busy done load en cnt exp lv
    vecs[0]  = '{1, 0, 0, 0, 5,   0,    0,   0,   0,  0, 0,  0,  0};
    vecs[1]  = '{0, 0, 0, 0, 9,   1,    1,   0,   1,  0, 0,  0,  5};
    vecs[2]  = '{0, 0, 0, 0, 9,   2,    1,   0,   0,  1, 5,  0,  5};
    vecs[3]  = '{0, 0, 0, 0, 9,   2,    1,   0,   0,  1, 4,  0,  5};
    vecs[4]  = '{0, 0, 0, 0, 9,   2,    1,   0,   0,  1, 3,  0,  5};
    vecs[5]  = '{0, 0, 0, 0, 9,   2,    1,   0,   0,  1, 2,  0,  5};
    vecs[6]  = '{0, 0, 0, 0, 9,   2,    1,   0,   0,  1, 1,  0,  5};
    vecs[7]  = '{0, 0, 0, 0, 9,   2,    1,   0,   0,  0, 0,  0,  5};
    vecs[8]  = '{0, 0, 0, 0, 9,   4,    1,   1,   0,  0, 0,  1,  5};
    vecs[9]  = '{0, 0, 0, 0, 9,   0,    0,   0,   0,  0, 0,  1,  5};
    vecs[10] = '{0, 1, 1, 0, 9,   0,    0,   0,   0,  0, 0,  1,  5};
    for (int i = 0; i < 11; i++) begin
      cycle_in(0, vecs[i].st, vecs[i].sp, vecs[i].pa, vecs[i].ar, vecs[i].per);
      check($sformatf("vec%0d_state", i), state_o, vecs[i].e_state);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
      check($sformatf("vec%0d_done", i), done, vecs[i].e_done);
      check($sformatf("vec%0d_load", i), bus.cnt_load, vecs[i].e_load);
      check($sformatf("vec%0d_enable", i), bus.cnt_enable, vecs[i].e_en);
      check($sformatf("vec%0d_counter", i), counter_q, vecs[i].e_cnt);
      check($sformatf("vec%0d_expire", i), expire_count, vecs[i].e_exp);
      check($sformatf("vec%0d_load_value", i), bus.cnt_load_value, vecs[i].e_lv);
      check($sformatf("vec%0d_dec", i), bus.cnt_dec, 1);
    end

    // ---------------- pause for 3 cycles at counterN = 4 (period 8) ----------------
    cycle_in(0, 1, 0, 0, 0, 8);
    first_done = -1;
    n_done = 0;
    for (int off = 1; off <= 30; off++) begin
      cycle_in(0, 0, 0, (off >= 6 && off <= 8), 0, 8);
      if (off >= 6 && off <= 9) check("pause_hold_counter", counter_q, 4);
      if (off == 6) check("pause_rise_enable", bus.cnt_enable, 0);
      if (off == 7) check("pause_state", state_o, 3);
      if (done) begin
        n_done++;
        if (first_done < 0) first_done = off;
      end
    end
    check("pause_done_latency", first_done, 8 + 3 + 4);
    check("pause_done_count", n_done, 1);

    // ---------------- auto-reload, period 3, four expiries ----------------
    cycle_in(0, 1, 0, 0, 1, 3);
    dq.delete();
    for (int off = 1; off <= 40; off++) begin
      cycle_in(0, 0, 0, 0, (off < 24), 3);
      if (done) begin
        dq.push_back(off);
        check("ar_expire_at_done", expire_count, dq.size());
      end
      if (off == 25) check("ar_idle_after", state_o, 0);
    end
    check("ar_done_count", dq.size(), 4);
    if (dq.size() > 0) check("ar_first_done", dq[0], 6);
    for (int i = 1; i < dq.size(); i++) check("ar_spacing", dq[i] - dq[i-1], 6);

    // ---------------- stop at counterN = 7 (period 10), start ignored ----------------
    cycle_in(0, 1, 0, 0, 0, 10);
    for (int off = 1; off <= 14; off++) begin
      cycle_in(0, (off == 3), (off == 5), 0, 0, (off == 3) ? 2 : 10);
      if (off == 4) check("stop_start_ignored_lv", bus.cnt_load_value, 10);
      if (off == 5) begin
        check("stop_cycle_counter", counter_q, 7);
        check("stop_cycle_enable", bus.cnt_enable, 0);
        check("stop_cycle_state", state_o, 2);
      end
      if (off == 6) begin
        check("stop_next_state", state_o, 0);
        check("stop_next_busy", busy, 0);
        check("stop_next_expire", expire_count, 0);
      end
      if (off >= 6) check("stop_no_done", done, 0);
      if (off == 14) check("stop_counter_kept", counter_q, 7);
    end

    // ---------------- period 0 ----------------
    cycle_in(0, 1, 0, 0, 0, 0);
    first_done = -1;
    for (int off = 1; off <= 8; off++) begin
      cycle_in(0, 0, 0, 0, 0, 0);
      if (done && first_done < 0) begin
        first_done = off;
        check("p0_expire", expire_count, 1);
      end
    end
    check("p0_done_latency", first_done, 3);

    // ---------------- saturation with period 0, auto-reload ----------------
    cycle_in(0, 1, 0, 0, 1, 0);
    n_done = 0;
    for (int off = 1; off <= 905; off++) begin
      cycle_in(0, 0, 0, 0, 1, 0);
      if (done) begin
        n_done++;
        if (n_done == 254 || n_done == 255 || n_done == 256 || n_done == 300)
          check($sformatf("sat_expire_%0d", n_done), expire_count,
                (n_done > 255) ? 255 : n_done);
      end
    end
    check("sat_done_count", n_done, 301);
    seen_idle = 1'b0;
    for (int off = 0; off < 10 && !seen_idle; off++) begin
      cycle_in(0, 0, 0, 0, 0, 0);
      if (state_o == 3'd0) seen_idle = 1'b1;
    end
    check("sat_returns_idle", seen_idle, 1);
    check("sat_final_expire", expire_count, 255);

    // ---------------- randomized run against reference model ----------------
    cycle_in(1, 0, 0, 0, 0, 0);
    cycle_in(1, 0, 0, 0, 0, 0);
    m_active = 1'b0; m_held = 1'b0;
    m_load_at = -1; m_done_at = -1;
    m_per = 0; m_cnt = 0; m_exp = 0;
    r_pause = 1'b0; r_ar = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 4) == 0) r_pause = !r_pause;
      r_stop  = ($urandom_range(0, 39) == 0) && !(m_active && c == m_load_at);
      r_start = !r_stop && ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) r_ar = 1'($urandom_range(0, 1));
      r_per = $urandom_range(0, 6);
      cycle_in(0, r_start, r_stop, r_pause, r_ar, r_per);

      // Counting window: after the load cycle, before the done cycle.
      window = m_active && (c > m_load_at) && (c != m_done_at);
      e_en   = window && (m_cnt != 0) && !r_pause && !m_held && !r_stop;
      check("rnd_busy", busy, m_active);
      check("rnd_done", done, m_active && (c == m_done_at));
      check("rnd_load", bus.cnt_load, m_active && (c == m_load_at));
      check("rnd_enable", bus.cnt_enable, e_en);
      check("rnd_counter", counter_q, m_cnt);
      check("rnd_expire", expire_count, m_exp);
      check("rnd_load_value", bus.cnt_load_value, m_per);

      // Advance the schedule to the next cycle.
      if (!m_active) begin
        if (r_start) begin
          m_active = 1'b1; m_load_at = c + 1; m_done_at = -1;
          m_per = r_per; m_exp = 0; m_held = 1'b0;
        end
      end else if (r_stop) begin
        m_active = 1'b0; m_done_at = -1;
      end else if (c == m_load_at) begin
        m_cnt = m_per; m_held = 1'b0;
      end else if (c == m_done_at) begin
        if (r_ar) m_load_at = c + 1;
        else m_active = 1'b0;
        m_done_at = -1;
      end else if (m_cnt == 0) begin
        m_done_at = c + 1;
        if (m_exp < 255) m_exp++;
      end else if (r_pause || m_held) begin
        m_held = r_pause;
      end else begin
        m_cnt--;
      end
    end

    // ---------------- reset mid-count in RUN ----------------
    cycle_in(1, 0, 0, 0, 0, 0);
    cycle_in(0, 1, 0, 0, 0, 20);
    for (int off = 1; off <= 4; off++) cycle_in(0, 0, 0, 0, 0, 20);
    cycle_in(1, 0, 0, 0, 0, 20);
    check("rst_run_state_before", state_o, 2);
    check("rst_run_counter", counter_q, 17);
    check("rst_run_enable", bus.cnt_enable, 0);
    cycle_in(0, 0, 0, 0, 0, 20);
    check("rst_run_next_state", state_o, 0);
    check("rst_run_next_busy", busy, 0);
    check("rst_run_counter_kept", counter_q, 17);

    // ---------------- reset while PAUSED ----------------
    cycle_in(0, 1, 0, 0, 0, 20);
    for (int off = 1; off <= 3; off++) cycle_in(0, 0, 0, 0, 0, 20);
    cycle_in(0, 0, 0, 1, 0, 20);
    cycle_in(0, 0, 0, 1, 0, 20);
    check("rst_paused_state_before", state_o, 3);
    cycle_in(1, 0, 0, 1, 0, 20);
    cycle_in(0, 0, 0, 0, 0, 20);
    check("rst_paused_next_state", state_o, 0);
    check("rst_paused_next_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_sequencer.md
# counter_sequencer

Down-count timer controller that drives the loadable N-bit up/down counter in this lab's datapath through its `dec`/`enable`/`load`/`load_value` control ports, and observes the counter's `counterN` output as feedback. On `start` it latches a period, loads it into the counter and decrements it to zero, then signals `done`. It supports one-shot and auto-reload modes, pause/resume, abort, and a saturating count of expirations. It sits between the user-input logic (buttons/switches) and the counter instance on the board.

## Interface
- N, 32, width of the counter and of the period.
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high; returns block to IDLE on the next edge.
- start  in  1  level; accepted only in IDLE.
- stop  in  1  abort; highest priority after reset.
- pause  in  1  level; freezes counting while high.
- auto_reload  in  1  0 = one-shot, 1 = reload after each expiry; sampled in DONE.
- period  in  N  count length; sampled into period_q when start is accepted.
- counterN  in  N  feedback from the counter output.
- cnt_dec  out  1  counter direction; constant 1.
- cnt_enable  out  1  counter enable.
- cnt_load  out  1  counter synchronous load.
- cnt_load_value  out  N  equals period_q.
- busy  out  1  high when state ≠ IDLE.
- done  out  1  one-cycle pulse per expiry.
- expire_count  out  8  saturating number of expiries since the last accepted start.
- state_o  out  3  encoding: IDLE=0, LOAD=1, RUN=2, PAUSED=3, DONE=4.

## Operation
- Counter model: `load` has priority over `enable`; `load` makes `counterN` take `load_value` at the next edge; `enable` with `dec=1` decrements by 1 per cycle.
- Reset values: state IDLE, period_q 0, expire_count 0. All outputs are 0 except cnt_dec=1.
- The FSM is Moore with registered state. `cnt_enable` is the only output that depends on inputs.
- Transitions:
  - IDLE: on start, period_q ← period, expire_count ← 0, go to LOAD.
  - LOAD: cnt_load=1. Go to RUN unconditionally. pause is ignored in this state.
  - RUN: cnt_enable = (counterN ≠ 0) && !pause. If counterN == 0, go to DONE. Else if pause, go to PAUSED.
  - PAUSED: cnt_enable=0. When pause is low, go to RUN. counterN holds its value.
  - DONE: done=1 and expire_count increments (saturates at 255). Go to LOAD if auto_reload, else IDLE.
- stop in any non-IDLE state: go to IDLE at the next edge, and cnt_enable is forced to 0 in that cycle.
  - In the cycle where stop is high, the Moore outputs of the current state still appear, so done still pulses if stop arrives in DONE.
  - counterN and expire_count are left unchanged.
- Simultaneous inputs: stop beats pause, auto_reload and completion. start is ignored outside IDLE.
- Changing period while busy has no effect until the next accepted start.
- period = 0: LOAD loads 0, RUN sees 0 and goes straight to DONE.
- Counter wrap-around never occurs: enable is gated off at 0.

## Timing
- start high at cycle t → LOAD at t+1 → counterN = P at t+2 (RUN) → counterN = 0 at t+2+P → done at t+3+P. Latency from start to done is P+3 cycles.
- Auto-reload: consecutive done pulses are P+3 cycles apart.
- Pause held for k cycles during RUN adds k+1 cycles to latency: one cycle for the RUN→PAUSED→RUN hop, and counting freezes in the same cycle pause rises.
- busy rises at t+1 and falls on the edge after the DONE cycle (one-shot) or after the stop cycle.
- Reset asserted mid-count: IDLE at the next edge, and cnt_enable is 0 in the reset cycle.

## Test plan
- Reset, then one-shot with period=5 and start pulsed at cycle 0:
  - counterN reads 5,4,3,2,1,0 from cycle 2 to cycle 7.
  - done=1 only at cycle 8, and expire_count=1.
  - busy is high from cycles 1 to 8.
- Auto-reload with period=3, run 4 expiries: done pulses 6 cycles apart, expire_count=4.
- Pause raised with counterN=4 for 3 cycles, then released:
  - counterN holds at 4 throughout the pause.
  - done arrives 4 cycles later than the unpaused case.
- stop with counterN=7:
  - IDLE at the next edge, no done pulse.
  - counterN stays at 7 and expire_count is unchanged.
  - start issued during the run is ignored.
- period=0 with start: done pulses 3 cycles after start.
- Auto-reload run past 255 expiries with period=0: expire_count saturates at 255.
- Reset asserted while in PAUSED: state_o=0, busy=0 on the next edge.
